id_hazard_unit: RTL and testbench
=================================

# id_hazard_unit

Stall and flush controller for the ID stage of the 5-stage MIPS pipeline. It works with the ID forwarding unit, which can forward rs from EX/MEM or MEM/WB, and rt only from MEM/WB. When an instruction in ID needs an operand that cannot yet be forwarded, this block computes the required bubble count. It holds PC and IF/ID for that many cycles while injecting bubbles into ID/EX. It flushes IF/ID on a taken branch or jump, and keeps saturating stall and flush statistics.

## Interface
Parameters:
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IF_ID_rs, IF_ID_rt  in  5 each  source registers of the instruction in ID.
- ID_uses_rs, ID_uses_rt  in  1 each  the ID instruction reads rs / rt.
- ID_is_branch  in  1  beq/bne; compares rs and rt in ID.
- ID_is_jr  in  1  jr/jalr; uses rs in ID.
- Branch_taken  in  1  ID comparator result; valid only when ID_is_branch.
- Jump  in  1  j/jal in ID.
- ID_EX_RegWrite, ID_EX_MemRead  in  1 each  control bits of the instruction in EX.
- ID_EX_rd  in  5  destination of the instruction in EX.
- EX_MEM_RegWrite, EX_MEM_MemRead  in  1 each  control bits of the instruction in MEM.
- EX_MEM_rd  in  5  destination of the instruction in MEM.
- PC_Write  out  1  0 = hold PC.
- IF_ID_Write  out  1  0 = hold IF/ID.
- ID_EX_Flush  out  1  1 = load a bubble into ID/EX.
- IF_ID_Flush  out  1  1 = clear IF/ID (squash the fetched instruction).
- hazard_busy  out  1  1 = a multi-cycle stall is in progress.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of IF/ID flushes.

## Operation
Per-source match conditions (each only when the source register is non-zero):
- exA: ID_EX_RegWrite, ID_EX_rd == src, !ID_EX_MemRead
- exL: ID_EX_RegWrite, ID_EX_rd == src, ID_EX_MemRead
- memL: EX_MEM_RegWrite, EX_MEM_rd == src, EX_MEM_MemRead

Bubbles required, need = max over the rules below:
- rs with ID_is_branch or ID_is_jr: exA → 1, exL → 2, memL → 1.
- rt with ID_is_branch: exA → 2, exL → 2. Any EX_MEM_RegWrite match on rt → 1 (rt cannot be forwarded from EX/MEM).
- Any used source with no ID-stage compare: exL → 1. EX forwarding covers every other case.
- A source is considered only if its ID_uses_* bit is set. ID_is_branch implies both rs and rt are used.

FSM: a registered 2-bit counter cnt, reset 0.
- IDLE (cnt == 0):
  - need > 0 → stall this cycle; cnt <= need − 1.
  - need == 0 → no stall.
- STALL (cnt != 0): stall unconditionally; cnt <= cnt − 1. need is ignored.

Outputs:
- A stall cycle drives PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1. Otherwise these are 1, 1, 0.
- hazard_busy = (cnt != 0).
- IF_ID_Flush = !stall & ((ID_is_branch & Branch_taken) | Jump | ID_is_jr). It is never asserted in a stall cycle.

Statistics:
- stall_cycles increments on each stall cycle.
- flush_count increments on each IF_ID_Flush cycle.
- Both saturate at all ones and never wrap.

## Timing
- Stall, flush and busy outputs are combinational from cnt and the current-cycle inputs, so they are valid in the same cycle as the hazard.
- Counters and cnt update on the rising edge of clk.
- Reset (asynchronous, any cycle, including mid-stall):
  - cnt = 0, stall_cycles = 0, flush_count = 0.
  - While reset_n is low, outputs read PC_Write = 1, IF_ID_Write = 1, ID_EX_Flush = 0, hazard_busy = 0, and IF_ID_Flush is combinational from the inputs.
- A 2-bubble hazard gives exactly 2 consecutive stall cycles. The ID instruction proceeds on the third cycle.
- A branch that is stalled and then taken asserts IF_ID_Flush only in its first non-stall cycle.
- A register-0 destination never causes a stall.

## Test plan
- Load-use, non-branch: ID_EX_MemRead = 1, ID_EX_RegWrite = 1, ID_EX_rd = 8; ID add with rs = 8, ID_uses_rs = 1 → exactly 1 cycle with PC_Write = 0, ID_EX_Flush = 1; hazard_busy stays 0; stall_cycles = 1.
- beq after lw: ID_EX load to rd = 9; beq with rs = 9 → 2 stall cycles; hazard_busy = 1 in the second; then with Branch_taken = 1 → IF_ID_Flush = 1 for one cycle; flush_count = 1.
- beq rt after ALU op: ID_EX_rd = 10 (non-load); beq with rt = 10 → 2 stalls. The same case on rs → 1 stall.
- Register zero: ID_EX load to rd = 0; beq with rs = rt = 0 → no stall; with Branch_taken = 1 → IF_ID_Flush = 1 immediately.
- Reset mid-stall: in the first cycle of a 2-bubble stall, pulse reset_n low → cnt = 0 and both counters = 0 asynchronously. After release with no hazard inputs, PC_Write = 1.
- Saturation: force stall_cycles near 2^CNT_W − 1 (use CNT_W = 4, run 20 stall cycles) → stall_cycles holds at 15.

Source files
------------

// File: rtl/id_hazard_unit.sv
// ID-stage stall/flush controller: computes bubbles for operands the ID forwarding
// paths cannot supply yet, squashes IF/ID on taken control flow, keeps saturating stats.
module id_hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             ID_is_jr,
  input  logic             Branch_taken,
  input  logic             Jump,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_RegWrite,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             IF_ID_Flush,
  output logic             hazard_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0] cnt;
  logic [1:0] need;
  logic [1:0] need_rs;
  logic [1:0] need_rt;
  logic       src_rs, src_rt, cmp_rs;
  logic       ex_a_rs, ex_l_rs, mem_l_rs, mem_w_rs;
  logic       ex_a_rt, ex_l_rt, mem_w_rt;
  logic       stall;

  // A branch reads both sources even if the decoder did not flag them.
  assign src_rs = (ID_uses_rs | ID_is_branch) & (IF_ID_rs != 5'd0);
  assign src_rt = (ID_uses_rt | ID_is_branch) & (IF_ID_rt != 5'd0);
  assign cmp_rs = ID_is_branch | ID_is_jr;

  assign ex_a_rs  = ID_EX_RegWrite & (ID_EX_rd == IF_ID_rs) & ~ID_EX_MemRead;
  assign ex_l_rs  = ID_EX_RegWrite & (ID_EX_rd == IF_ID_rs) &  ID_EX_MemRead;
  assign mem_w_rs = EX_MEM_RegWrite & (EX_MEM_rd == IF_ID_rs);
  assign mem_l_rs = mem_w_rs & EX_MEM_MemRead;

  assign ex_a_rt  = ID_EX_RegWrite & (ID_EX_rd == IF_ID_rt) & ~ID_EX_MemRead;
  assign ex_l_rt  = ID_EX_RegWrite & (ID_EX_rd == IF_ID_rt) &  ID_EX_MemRead;
  assign mem_w_rt = EX_MEM_RegWrite & (EX_MEM_rd == IF_ID_rt);

  always_comb begin
    need_rs = '0;
    if (src_rs) begin
      if (cmp_rs) begin
        if (ex_l_rs)                   need_rs = 2'd2;
        else if (ex_a_rs || mem_l_rs)  need_rs = 2'd1;
      end else if (ex_l_rs) begin
        need_rs = 2'd1;
      end
    end
  end

  // rt has no EX/MEM forwarding path into the ID comparator, so any MEM-stage
  // writer of rt costs a bubble for a branch.
  always_comb begin
    need_rt = '0;
    if (src_rt) begin
      if (ID_is_branch) begin
        if (ex_a_rt || ex_l_rt) need_rt = 2'd2;
        else if (mem_w_rt)      need_rt = 2'd1;
      end else if (ex_l_rt) begin
        need_rt = 2'd1;
      end
    end
  end

  assign need = (need_rs > need_rt) ? need_rs : need_rt;

  assign stall       = reset_n & ((cnt != 2'd0) | (need != 2'd0));
  assign hazard_busy = (cnt != 2'd0);
  assign PC_Write    = ~stall;
  assign IF_ID_Write = ~stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = ~stall & ((ID_is_branch & Branch_taken) | Jump | ID_is_jr);

  // Once counting down, the remaining bubbles are committed regardless of need.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end else if (need != 2'd0) begin
      cnt <= need - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (IF_ID_Flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Vector table plus hand-written sequences for id_hazard_unit; per-cycle expected
// outputs go through a queue and are compared on the falling edge.
module tb_id_hazard_unit;

  localparam int unsigned CW   = 4;
  localparam int unsigned SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    IF_ID_rs, IF_ID_rt, ID_EX_rd, EX_MEM_rd;
  logic          ID_uses_rs, ID_uses_rt, ID_is_branch, ID_is_jr, Branch_taken, Jump;
  logic          ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_RegWrite, EX_MEM_MemRead;
  logic          PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, hazard_busy;
  logic [CW-1:0] stall_cycles, flush_count;

  id_hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_is_branch(ID_is_branch), .ID_is_jr(ID_is_jr),
    .Branch_taken(Branch_taken), .Jump(Jump),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
    .IF_ID_Flush(IF_ID_Flush), .hazard_busy(hazard_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt;
    logic        urs, urt, br, jr, tk, jmp, exw, exm;
    logic [4:0]  exd;
    logic        mw, mm;
    logic [4:0]  md;
    int unsigned need;
    logic        fl;
  } vec_t;

  typedef struct {
    logic [4:0] o;      // {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, hazard_busy}
    string      tag;
  } exp_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];
  vec_t        tbl[$];
  int unsigned exp_st, exp_fl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, {27'd0, PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, hazard_busy},
          {27'd0, e.o});
    end
  end

  function automatic vec_t mk(
      input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
      input logic br, input logic jr, input logic tk, input logic jmp,
      input logic exw, input logic exm, input logic [4:0] exd,
      input logic mw, input logic mm, input logic [4:0] md,
      input int unsigned need, input logic fl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.jr = jr;
    v.tk = tk; v.jmp = jmp; v.exw = exw; v.exm = exm; v.exd = exd;
    v.mw = mw; v.mm = mm; v.md = md; v.need = need; v.fl = fl;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    IF_ID_rs = v.rs; IF_ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
    ID_is_branch = v.br; ID_is_jr = v.jr; Branch_taken = v.tk; Jump = v.jmp;
    ID_EX_RegWrite = v.exw; ID_EX_MemRead = v.exm; ID_EX_rd = v.exd;
    EX_MEM_RegWrite = v.mw; EX_MEM_MemRead = v.mm; EX_MEM_rd = v.md;
  endtask

  task automatic idle_inputs();
    apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0));
  endtask

  task automatic push(input logic stall, input logic fl, input logic busy, input string tag);
    exp_t e;
    e.o   = {~stall, ~stall, stall, fl, busy};
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic int unsigned sat(input int unsigned a);
    return (a > SMAX) ? SMAX : a;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lu, beq_lw, v;
    //            rs     rt     urs urt br jr tk jmp exw exm exd    mw mm md     need fl
    tbl.push_back(mk(5'd0, 5'd0,  0, 0, 0, 0, 0, 0,  0, 0, 5'd0,  0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd8, 5'd0,  1, 0, 0, 0, 0, 0,  1, 1, 5'd8,  0, 0, 5'd0,  1, 0));
    tbl.push_back(mk(5'd8, 5'd0,  1, 0, 0, 0, 0, 0,  1, 0, 5'd8,  0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd9, 5'd0,  1, 1, 1, 0, 0, 0,  1, 1, 5'd9,  0, 0, 5'd0,  2, 0));
    tbl.push_back(mk(5'd1, 5'd10, 1, 1, 1, 0, 1, 0,  1, 0, 5'd10, 0, 0, 5'd0,  2, 0));
    tbl.push_back(mk(5'd10,5'd1,  1, 1, 1, 0, 1, 0,  1, 0, 5'd10, 0, 0, 5'd0,  1, 0));
    tbl.push_back(mk(5'd0, 5'd0,  1, 1, 1, 0, 1, 0,  1, 1, 5'd0,  0, 0, 5'd0,  0, 1));
    tbl.push_back(mk(5'd11,5'd0,  1, 0, 0, 1, 0, 0,  0, 0, 5'd0,  1, 1, 5'd11, 1, 0));
    tbl.push_back(mk(5'd11,5'd0,  1, 0, 0, 1, 0, 0,  0, 0, 5'd0,  1, 0, 5'd11, 0, 1));
    tbl.push_back(mk(5'd2, 5'd12, 1, 1, 1, 0, 0, 0,  0, 0, 5'd0,  1, 0, 5'd12, 1, 0));
    tbl.push_back(mk(5'd2, 5'd12, 1, 1, 0, 0, 0, 0,  0, 0, 5'd0,  1, 0, 5'd12, 0, 0));
    tbl.push_back(mk(5'd2, 5'd13, 1, 1, 0, 0, 0, 0,  1, 1, 5'd13, 0, 0, 5'd0,  1, 0));
    tbl.push_back(mk(5'd2, 5'd13, 1, 0, 0, 0, 0, 0,  1, 1, 5'd13, 0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd0, 5'd0,  0, 0, 0, 0, 0, 1,  0, 0, 5'd0,  0, 0, 5'd0,  0, 1));
    tbl.push_back(mk(5'd3, 5'd4,  1, 1, 1, 0, 0, 0,  0, 0, 5'd0,  0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd5, 5'd6,  1, 1, 1, 0, 1, 0,  1, 0, 5'd5,  1, 0, 5'd6,  1, 0));
    tbl.push_back(mk(5'd7, 5'd3,  1, 1, 1, 0, 1, 0,  1, 1, 5'd7,  1, 0, 5'd3,  2, 0));
    tbl.push_back(mk(5'd0, 5'd0,  0, 0, 0, 0, 1, 0,  0, 0, 5'd0,  0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd8, 5'd0,  1, 0, 0, 0, 0, 0,  0, 1, 5'd8,  0, 0, 5'd0,  0, 0));
    tbl.push_back(mk(5'd14,5'd0,  1, 0, 0, 1, 0, 0,  1, 1, 5'd14, 0, 0, 5'd0,  2, 0));

    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset_outputs", {27'd0, PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, hazard_busy},
        32'b11000);
    chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset_flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    exp_st = 0;
    exp_fl = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge clk); #1;
      apply(v);
      push(v.need > 0, v.fl, 1'b0, $sformatf("vec%0d_c0", i));
      exp_st = sat(exp_st + v.need);
      if (v.fl) exp_fl = sat(exp_fl + 1);
      if (v.need == 2) begin
        @(posedge clk); #1;
        push(1'b1, 1'b0, 1'b1, $sformatf("vec%0d_c1", i));
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    chk("table_stall_cycles", 32'(stall_cycles), exp_st);
    chk("table_flush_count", 32'(flush_count), exp_fl);

    // Load-use: one bubble, never busy.
    lu = mk(5'd8, 5'd0, 1, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 0, 5'd0, 1, 0);
    do_reset();
    @(posedge clk); #1;
    apply(lu);
    push(1'b1, 1'b0, 1'b0, "loaduse_c0");
    @(posedge clk); #1;
    idle_inputs();
    push(1'b0, 1'b0, 1'b0, "loaduse_c1");
    chk("loaduse_stall_cycles", 32'(stall_cycles), 32'd1);

    // beq after lw, taken: two stalls, then a single flush cycle.
    beq_lw = mk(5'd9, 5'd0, 1, 1, 1, 0, 1, 0, 1, 1, 5'd9, 0, 0, 5'd0, 2, 0);
    @(posedge clk); #1;
    apply(beq_lw);
    push(1'b1, 1'b0, 1'b0, "beqlw_c0");
    @(posedge clk); #1;
    push(1'b1, 1'b0, 1'b1, "beqlw_c1");
    @(posedge clk); #1;
    apply(mk(5'd9, 5'd0, 1, 1, 1, 0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1));
    push(1'b0, 1'b1, 1'b0, "beqlw_c2");
    @(posedge clk); #1;
    idle_inputs();
    push(1'b0, 1'b0, 1'b0, "beqlw_c3");
    chk("beqlw_stall_cycles", 32'(stall_cycles), 32'd3);
    chk("beqlw_flush_count", 32'(flush_count), 32'd1);

    // Reset pulse in the first cycle of a two-bubble stall.
    @(posedge clk); #1;
    apply(beq_lw);
    #1;
    chk("midstall_pre_pcw", 32'(PC_Write), 32'd0);
    chk("midstall_pre_iff", 32'(IF_ID_Flush), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midstall_rst_outs", {27'd0, PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, hazard_busy},
        32'b11010);
    chk("midstall_rst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("midstall_rst_flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    #1;
    chk("midstall_post_pcw", 32'(PC_Write), 32'd1);
    @(posedge clk); #1;
    chk("midstall_post_busy", 32'(hazard_busy), 32'd0);
    chk("midstall_post_pcw2", 32'(PC_Write), 32'd1);

    // Saturation: 20 consecutive single-bubble stalls on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      apply(lu);
      push(1'b1, 1'b0, 1'b0, $sformatf("sat_c%0d", i));
    end
    @(posedge clk); #1;
    idle_inputs();
    chk("sat_stall_cycles", 32'(stall_cycles), SMAX);
    chk("sat_flush_count", 32'(flush_count), 32'd0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
